// File: rtl/memory_text_reader_pkg.sv
// Shared types and constants for the text reader: FSM state encoding,
// the lane type and the number of bytes per fetched word.
package memory_text_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [1:0] lane_t;

  localparam int BYTES_PER_WORD = 4;
  localparam lane_t LANE_LAST = lane_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/memory_text_reader_byte_unpacker.sv
// Selects one byte of a big-endian 32-bit word; lane 0 is the most
// significant byte, i.e. the lowest memory address.
module text_byte_unpacker
  import memory_text_reader_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  output logic [7:0]  data
);

  always_comb begin
    data = word[31:24];
    case (lane_t'(lane))
      2'd0: data = word[31:24];
      2'd1: data = word[23:16];
      2'd2: data = word[15:8];
      2'd3: data = word[7:0];
      default: data = word[31:24];
    endcase
  end

endmodule

// File: rtl/memory_text_reader.sv
// Streams a byte range of dataMemory out one byte at a time, fetching a
// 32-bit word per four bytes. Define TEXT_READER_NULL_STOP_EN to end on 0x00.
module memory_text_reader
  import memory_text_reader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              busy,
  output logic              done,
  output logic              null_hit
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;
  lane_t             lane;
  logic [31:0]       wbuf;
  logic              accept;
  logic              xfer;
  logic              is_null;
  logic              last_byte;

  text_byte_unpacker u_unpacker (
    .word (wbuf),
    .lane (lane),
    .data (byte_data)
  );

  assign xfer = (state == STREAM) && byte_ready;

`ifdef TEXT_READER_NULL_STOP_EN
  logic null_flag;
  assign is_null  = (byte_data == 8'h00);
  assign null_hit = (state == DONE) && null_flag;
`else
  assign is_null  = 1'b0;
  assign null_hit = 1'b0;
`endif

  assign last_byte = (remaining == LEN_W'(1)) || is_null;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      addr_q    <= '0;
      remaining <= '0;
      lane      <= '0;
      wbuf      <= '0;
`ifdef TEXT_READER_NULL_STOP_EN
      null_flag <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        ptr       <= base_addr;
        remaining <= length;
        lane      <= '0;
      end
      if (state == FETCH) begin
        wbuf   <= mem_rdata;
        addr_q <= ptr;
      end
      if (xfer) begin
        ptr       <= ptr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
        lane      <= lane + lane_t'(1);
      end
`ifdef TEXT_READER_NULL_STOP_EN
      if (state == IDLE) begin
        null_flag <= 1'b0;
      end else if (xfer) begin
        null_flag <= is_null;
      end
`endif
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = DONE;
          end
        end
      end
      FETCH:  state_next = STREAM;
      STREAM: begin
        if (xfer) begin
          if (last_byte) begin
            state_next = DONE;
          end else if (lane == LANE_LAST) begin
            state_next = FETCH;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The address is driven from ptr only while fetching; otherwise it holds.
  assign mem_addr   = (state == FETCH) ? ptr : addr_q;
  assign mem_we     = 1'b0;
  assign byte_valid = (state == STREAM);
  assign busy       = (state == FETCH) || (state == STREAM);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_memory_text_reader.sv
// Directed bench for memory_text_reader: a byte-array RAM model, an expected
// byte queue and an expected fetch-address queue built from that model.
module tb_memory_text_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [31:0] mem_rdata;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       busy;
  logic       done;
  logic       null_hit;

  logic [7:0] ram [256];
  logic [7:0] exp_q[$];
  logic [7:0] fetch_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = {ram[mem_addr], ram[mem_addr + 8'd1],
                      ram[mem_addr + 8'd2], ram[mem_addr + 8'd3]};

  memory_text_reader #(.ADDR_W(8), .LEN_W(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .busy       (busy),
    .done       (done),
    .null_hit   (null_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer from start to done (or to a reset abort after abort_after bytes).
  task automatic run(input string name, input logic [7:0] b, input logic [8:0] n,
                     input bit toggle, input int glitch_at, input int abort_after,
                     input int exp_done_cycle);
    int         cyc;
    int         nxfer;
    bit         finished;
    bit         stall_prev;
    bit         we_bad;
    bit         stable_bad;
    bit         null_exp;
    logic [7:0] prev_data;
    logic [7:0] a;
    logic [7:0] v;

    exp_q.delete();
    fetch_q.delete();
    null_exp = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      a = 8'(int'(b) + i);
      v = ram[a];
      if (i % 4 == 0) fetch_q.push_back(a);
      exp_q.push_back(v);
`ifdef TEXT_READER_NULL_STOP_EN
      if (v == 8'h00) begin
        null_exp = 1'b1;
        break;
      end
`endif
    end

    @(negedge clk);
    start = 1'b1; base_addr = b; length = n; byte_ready = 1'b1;
    cyc = 0; nxfer = 0; finished = 1'b0; stall_prev = 1'b0;
    we_bad = 1'b0; stable_bad = 1'b0; prev_data = 8'h00;

    while (!finished && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (glitch_at == cyc) begin
        start = 1'b1; base_addr = 8'h80; length = 9'd7;
      end else begin
        start = 1'b0; base_addr = b; length = n;
      end
      if (mem_we !== 1'b0) we_bad = 1'b1;

      if (abort_after > 0 && nxfer == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        chk({name, "_reset_outputs"},
            {11'd0, byte_valid, done, busy, null_hit, mem_we, mem_addr, byte_data}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (done || busy || byte_valid) stable_bad = 1'b1;
        end
        chk({name, "_idle_after_abort"}, {31'd0, stable_bad}, 32'd0);
        finished = 1'b1;
      end else begin
        byte_ready = toggle ? cyc[0] : 1'b1;
        if (byte_valid && stall_prev && byte_data !== prev_data) stable_bad = 1'b1;
        if (busy && !byte_valid) begin
          if (fetch_q.size() == 0) chk({name, "_extra_fetch"}, {24'd0, mem_addr}, 32'hffff_ffff);
          else chk({name, "_fetch_addr"}, {24'd0, mem_addr}, {24'd0, fetch_q.pop_front()});
        end
        if (byte_valid && byte_ready) begin
          nxfer++;
          if (exp_q.size() == 0) chk({name, "_extra_byte"}, {24'd0, byte_data}, 32'hffff_ffff);
          else chk({name, "_byte"}, {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
        end
        stall_prev = byte_valid && !byte_ready;
        prev_data  = byte_data;
        if (done) begin
          if (exp_done_cycle > 0) chk({name, "_done_cycle"}, cyc, exp_done_cycle);
          chk({name, "_null_hit"}, {31'd0, null_hit}, {31'd0, null_exp});
          chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
          chk({name, "_bytes_left"}, exp_q.size(), 32'd0);
          chk({name, "_fetches_left"}, fetch_q.size(), 32'd0);
          chk({name, "_stall_stable"}, {31'd0, stable_bad}, 32'd0);
          @(negedge clk);
          start = 1'b0;
          chk({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
          finished = 1'b1;
        end
      end
    end
    if (!finished) chk({name, "_timeout"}, 32'd0, 32'd1);
    chk({name, "_mem_we"}, {31'd0, we_bad}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5a;
    ram[8'h10] = 8'h48; ram[8'h11] = 8'h4f; ram[8'h12] = 8'h4c; ram[8'h13] = 8'h41;
    ram[8'hfe] = 8'h11; ram[8'hff] = 8'h22; ram[8'h00] = 8'h33; ram[8'h01] = 8'h44;
    ram[8'h30] = 8'h41; ram[8'h31] = 8'h00; ram[8'h32] = 8'h42;

    rst = 1'b1; start = 1'b0; base_addr = 8'h00; length = 9'd0; byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {11'd0, byte_valid, done, busy, null_hit, mem_we, mem_addr, byte_data}, 32'd0);
    rst = 1'b0;

    run("aligned",      8'h10, 9'd4, 1'b0, 0, 0, 6);
    run("backpressure", 8'h20, 9'd6, 1'b1, 4, 0, 0);
    run("wrap",         8'hfe, 9'd4, 1'b0, 0, 0, 6);
    run("zero_len",     8'h50, 9'd0, 1'b0, 0, 0, 1);
    run("abort",        8'h40, 9'd5, 1'b0, 0, 2, 0);
    run("after_abort",  8'h40, 9'd5, 1'b0, 0, 0, 8);
`ifdef TEXT_READER_NULL_STOP_EN
    run("null_stop",    8'h30, 9'd3, 1'b0, 0, 0, 4);
`else
    run("null_stop",    8'h30, 9'd3, 1'b0, 0, 0, 5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
